// File: rtl/mux_result_checker.sv
// mux_result_checker
//   Clocked checker that sits behind a 4-to-1 mux pair. Each accepted sample
//   carries the select/data vector plus the reference (out_a) and
//   implementation (out_b) mux outputs. The checker recomputes the golden
//   result din[sel], counts samples and mismatches, captures the first
//   failing vector and reports pass/fail once the run completes.
//
//   Ports
//     clk             rising-edge clock
//     rst             asynchronous active-high reset
//     start           one-cycle pulse, begins a run from IDLE or DONE
//     valid           sample strobe qualifying sel/din/out_a/out_b
//     sel             mux select {s1,s0}
//     din             mux data {in3,in2,in1,in0}
//     out_a           reference-model mux output
//     out_b           implementation mux output
//     busy            run in progress (RUN or DRAIN)
//     done            run complete, results held
//     pass            meaningful while done: no mismatches seen
//     sample_cnt      samples accepted this run
//     err_cnt         mismatching samples this run, saturating
//     first_err_valid first_err_info holds a captured failure
//     first_err_info  {a_bad,b_bad,out_b,out_a,sel[1:0],din[3:0]}
module mux_result_checker #(
  parameter int NUM_SAMPLES = 2000,
  parameter int CNT_W       = 16,
  parameter int MAX_ERR     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic [1:0]       sel,
  input  logic [3:0]       din,
  input  logic             out_a,
  input  logic             out_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [9:0]       first_err_info
);

  // Completion is tracked with its own counter sized for NUM_SAMPLES so the
  // run length does not depend on the width of the reported counters.
  localparam int                 ACC_W    = $clog2(NUM_SAMPLES + 1);
  localparam logic [ACC_W-1:0]   LAST_IDX = ACC_W'(NUM_SAMPLES - 1);
  localparam bit                 ABORT_EN = (MAX_ERR != 0);
  localparam logic [CNT_W-1:0]   ABORT_AT = CNT_W'(MAX_ERR);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [ACC_W-1:0] acc_cnt;
  logic             drain_cnt;

  // Stage 1: registered copy of the accepted sample.
  logic             s1_valid;
  logic [1:0]       s1_sel;
  logic [3:0]       s1_din;
  logic             s1_a;
  logic             s1_b;

  // Stage 2: comparison against the golden mux result.
  logic             golden;
  logic             a_bad;
  logic             b_bad;
  logic             mismatch;
  logic [CNT_W-1:0] err_nxt;

  logic             accept;
  logic             run_start;
  logic             last_sample;
  logic             abort;
  logic             drain_end;

  assign accept      = (state == RUN) && valid;
  assign run_start   = start && ((state == IDLE) || (state == DONE));
  assign last_sample = accept && (acc_cnt == LAST_IDX);

  assign golden   = s1_din[s1_sel];
  assign a_bad    = (s1_a != golden);
  assign b_bad    = (s1_b != golden);
  assign mismatch = s1_valid && (a_bad || b_bad);

  always_comb begin
    err_nxt = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_nxt = err_cnt + CNT_W'(1);
    end
  end

  // Abort looks at the error count including this cycle's stage-2 result so
  // the run closes on the same edge the limiting error lands; a sample
  // accepted on that edge is still carried through the pipeline.
  assign abort     = ABORT_EN && (err_nxt >= ABORT_AT);
  assign drain_end = (state == DRAIN) && drain_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_sample || abort) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DRAIN always spans two cycles: enough for a sample accepted on the
  // closing edge to pass stage 1 and land in the error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) && !drain_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_din   <= '0;
      s1_a     <= 1'b0;
      s1_b     <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sel <= sel;
        s1_din <= din;
        s1_a   <= out_a;
        s1_b   <= out_b;
      end
    end
  end

  // sample_cnt is a plain counter; it only needs to hold NUM_SAMPLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt    <= '0;
      sample_cnt <= '0;
    end else if (run_start) begin
      acc_cnt    <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      acc_cnt    <= acc_cnt + ACC_W'(1);
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_info  <= '0;
    end else if (run_start) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_info  <= '0;
    end else begin
      err_cnt <= err_nxt;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_info  <= {a_bad, b_bad, s1_b, s1_a, s1_sel, s1_din};
      end
    end
  end

  // pass is latched on the DONE entry edge from the final error count and
  // cleared whenever a new run starts, so it reads 0 outside DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (run_start) begin
      pass <= 1'b0;
    end else if (drain_end) begin
      pass <= (err_nxt == '0);
    end
  end

endmodule

// File: tb/tb_mux_result_checker.sv
module tb_mux_result_checker;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] sel   = '0;
  logic [3:0] din   = '0;
  logic       out_a = 1'b0;
  logic       out_b = 1'b0;

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  bit cmp_en = 1'b0;

  // u0: abort on first error; u1: never abort; u2: narrow counters
  logic        b0, dn0, p0, f0;
  logic [15:0] sc0, ec0;
  logic [9:0]  i0;
  logic        b1, dn1, p1, f1;
  logic [15:0] sc1, ec1;
  logic [9:0]  i1;
  logic        b2, dn2, p2, f2;
  logic [2:0]  sc2, ec2;
  logic [9:0]  i2;

  mux_result_checker #(.NUM_SAMPLES(8), .CNT_W(16), .MAX_ERR(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .sel(sel), .din(din),
    .out_a(out_a), .out_b(out_b), .busy(b0), .done(dn0), .pass(p0),
    .sample_cnt(sc0), .err_cnt(ec0), .first_err_valid(f0), .first_err_info(i0));

  mux_result_checker #(.NUM_SAMPLES(8), .CNT_W(16), .MAX_ERR(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .sel(sel), .din(din),
    .out_a(out_a), .out_b(out_b), .busy(b1), .done(dn1), .pass(p1),
    .sample_cnt(sc1), .err_cnt(ec1), .first_err_valid(f1), .first_err_info(i1));

  mux_result_checker #(.NUM_SAMPLES(10), .CNT_W(3), .MAX_ERR(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .sel(sel), .din(din),
    .out_a(out_a), .out_b(out_b), .busy(b2), .done(dn2), .pass(p2),
    .sample_cnt(sc2), .err_cnt(ec2), .first_err_valid(f2), .first_err_info(i2));

  logic        d_busy[3], d_done[3], d_pass[3], d_fev[3];
  logic [15:0] d_scnt[3], d_ecnt[3];
  logic [9:0]  d_info[3];

  assign d_busy[0] = b0;  assign d_busy[1] = b1;  assign d_busy[2] = b2;
  assign d_done[0] = dn0; assign d_done[1] = dn1; assign d_done[2] = dn2;
  assign d_pass[0] = p0;  assign d_pass[1] = p1;  assign d_pass[2] = p2;
  assign d_fev[0]  = f0;  assign d_fev[1]  = f1;  assign d_fev[2]  = f2;
  assign d_scnt[0] = sc0; assign d_scnt[1] = sc1; assign d_scnt[2] = {13'b0, sc2};
  assign d_ecnt[0] = ec0; assign d_ecnt[1] = ec1; assign d_ecnt[2] = {13'b0, ec2};
  assign d_info[0] = i0;  assign d_info[1] = i1;  assign d_info[2] = i2;

  function automatic int ns_of(input int k);
    return (k == 2) ? 10 : 8;
  endfunction
  function automatic int me_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction
  function automatic int w_of(input int k);
    return (k == 2) ? 3 : 16;
  endfunction
  function automatic logic gold(input logic [1:0] s, input logic [3:0] d);
    return d[s];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is "open" while samples are accepted; it closes on reaching the
  // sample budget or the error limit, and reports done two edges later.
  // Each accepted sample is judged on the edge after its acceptance.
  bit         m_busy[3], m_open[3], m_fin[3], m_pass[3], m_fv[3], m_pend[3];
  int         m_acc[3], m_ecnt[3], m_done_at[3];
  logic [9:0] m_info[3];
  logic [1:0] m_p_sel[3];
  logic [3:0] m_p_din[3];
  logic       m_p_a[3], m_p_b[3];
  int         edge_n = 0;

  task automatic m_reset(input int k);
    m_busy[k] = 0; m_open[k] = 0; m_fin[k] = 0; m_pass[k] = 0; m_fv[k] = 0;
    m_pend[k] = 0; m_acc[k] = 0; m_ecnt[k] = 0; m_done_at[k] = 0; m_info[k] = '0;
  endtask

  task automatic m_step(input int k);
    bit   was_busy;
    logic g, ab, bb;
    was_busy = m_busy[k];
    if (m_pend[k]) begin
      g  = gold(m_p_sel[k], m_p_din[k]);
      ab = (m_p_a[k] != g);
      bb = (m_p_b[k] != g);
      if (ab || bb) begin
        if (m_ecnt[k] < (1 << w_of(k)) - 1) m_ecnt[k]++;
        if (!m_fv[k]) begin
          m_fv[k]   = 1;
          m_info[k] = {ab, bb, m_p_b[k], m_p_a[k], m_p_sel[k], m_p_din[k]};
        end
      end
      m_pend[k] = 0;
    end
    if (m_open[k] && valid) begin
      m_acc[k]++;
      m_pend[k] = 1; m_p_sel[k] = sel; m_p_din[k] = din; m_p_a[k] = out_a; m_p_b[k] = out_b;
    end
    if (m_open[k] && (m_acc[k] == ns_of(k) || (me_of(k) != 0 && m_ecnt[k] >= me_of(k)))) begin
      m_open[k]    = 0;
      m_done_at[k] = edge_n + 2;
    end else if (was_busy && !m_open[k] && edge_n == m_done_at[k]) begin
      m_busy[k] = 0;
      m_fin[k]  = 1;
      m_pass[k] = (m_ecnt[k] == 0);
    end
    if (start && !was_busy) begin
      m_reset(k);
      m_busy[k] = 1;
      m_open[k] = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) m_reset(k);
    end else begin
      edge_n++;
      for (int k = 0; k < 3; k++) m_step(k);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.busy", k), 32'(d_busy[k]), 32'(m_busy[k]));
        chk($sformatf("u%0d.done", k), 32'(d_done[k]), 32'(m_fin[k]));
        chk($sformatf("u%0d.pass", k), 32'(d_pass[k]), 32'(m_pass[k]));
        // a sample count beyond the counter width has no defined reading
        if (m_acc[k] < (1 << w_of(k)))
          chk($sformatf("u%0d.sample_cnt", k), 32'(d_scnt[k]), 32'(m_acc[k]));
        chk($sformatf("u%0d.err_cnt", k), 32'(d_ecnt[k]), 32'(m_ecnt[k]));
        chk($sformatf("u%0d.first_err_valid", k), 32'(d_fev[k]), 32'(m_fv[k]));
        chk($sformatf("u%0d.first_err_info", k), 32'(d_info[k]), 32'(m_info[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic st, input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic a, input logic b);
    start = st; valid = v; sel = s; din = d; out_a = a; out_b = b;
    @(posedge clk); #1;
  endtask

  task automatic good(input logic st, input logic [1:0] s, input logic [3:0] d);
    drive(st, 1'b1, s, d, gold(s, d), gold(s, d));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    start = 1'b0; valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    start = 1'b0; valid = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (d_done[k]) break;
      @(posedge clk); #1;
    end
    chk($sformatf("u%0d.done_within_%0d", k, budget), 32'(d_done[k]), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    chk("reset.busy", 32'(b0), 32'd0);
    chk("reset.sample_cnt", 32'(sc0), 32'd0);

    // clean run with gating of valid in IDLE and start in RUN
    good(1'b0, 2'b01, 4'b0010);
    good(1'b0, 2'b11, 4'b1000);
    chk("idle_valid.sample_cnt", 32'(sc0), 32'd0);
    chk("idle_valid.busy", 32'(b0), 32'd0);
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("start.busy", 32'(b0), 32'd1);
    for (int i = 0; i < 8; i++) good((i == 2 || i == 5), 2'(i), 4'(i * 5 + 3));
    chk("clean.sample_cnt", 32'(sc0), 32'd8);
    chk("clean.done_t1", 32'(dn0), 32'd0);
    idle();
    chk("clean.done_t2", 32'(dn0), 32'd0);
    idle();
    chk("clean.done_t3", 32'(dn0), 32'd1);
    chk("clean.pass", 32'(p0), 32'd1);
    chk("clean.err_cnt", 32'(ec0), 32'd0);
    chk("clean.first_err_valid", 32'(f0), 32'd0);
    good(1'b0, 2'b00, 4'b0001);
    good(1'b0, 2'b10, 4'b0100);
    chk("done_valid.sample_cnt", 32'(sc0), 32'd8);
    chk("done_valid.done", 32'(dn0), 32'd1);

    // restart from DONE, then asynchronous reset between edges
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("restart.busy", 32'(b0), 32'd1);
    chk("restart.sample_cnt", 32'(sc0), 32'd0);
    chk("restart.pass", 32'(p0), 32'd0);
    good(1'b0, 2'b00, 4'b1111);
    good(1'b0, 2'b01, 4'b0101);
    good(1'b0, 2'b10, 4'b0011);
    chk("pre_reset.sample_cnt", 32'(sc0), 32'd3);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset.busy", 32'(b0), 32'd0);
    chk("async_reset.done", 32'(dn0), 32'd0);
    chk("async_reset.sample_cnt", 32'(sc0), 32'd0);
    chk("async_reset.u2_sample_cnt", 32'(sc2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("fresh.sample_cnt", 32'(sc0), 32'd0);
    good(1'b0, 2'b11, 4'b1001);
    good(1'b0, 2'b00, 4'b0110);
    idle();
    chk("fresh.sample_cnt_2", 32'(sc0), 32'd2);
    chk("fresh.busy", 32'(b0), 32'd1);

    // implementation fault, no abort (u1)
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) drive(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1, 1'b0);
      else        good(1'b0, 2'(i), 4'(i * 5 + 3));
    end
    wait_done(1, 10);
    chk("fault.sample_cnt", 32'(sc1), 32'd8);
    chk("fault.err_cnt", 32'(ec1), 32'd1);
    chk("fault.first_err_valid", 32'(f1), 32'd1);
    chk("fault.first_err_info", 32'(i1), 32'(10'b01_0_1_10_0100));
    chk("fault.pass", 32'(p1), 32'd0);

    // abort on third sample with two more back-to-back (u0)
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    good(1'b0, 2'b00, 4'b0011);
    good(1'b0, 2'b11, 4'b1100);
    drive(1'b0, 1'b1, 2'b01, 4'b1010, 1'b0, 1'b1);
    good(1'b0, 2'b10, 4'b0110);
    good(1'b0, 2'b01, 4'b0001);
    wait_done(0, 10);
    chk("abort.sample_cnt", 32'(sc0), 32'd4);
    chk("abort.err_cnt", 32'(ec0), 32'd1);
    chk("abort.pass", 32'(p0), 32'd0);
    chk("abort.first_err_info", 32'(i0), 32'(10'b10_1_0_01_1010));
    chk("abort.busy", 32'(b0), 32'd0);

    // saturation of a 3-bit error counter (u2)
    do_reset();
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] s;
      logic [3:0] d;
      s = 2'(i);
      d = 4'(i * 7 + 1);
      drive(1'b0, 1'b1, s, d, ~gold(s, d), ~gold(s, d));
    end
    wait_done(2, 10);
    chk("sat.err_cnt", 32'(ec2), 32'd7);
    chk("sat.pass", 32'(p2), 32'd0);
    chk("sat.u1_err_cnt", 32'(ec1), 32'd8);

    idle();
    idle();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
